// File: rtl/div_unit.sv
// div_unit: iterative 32-bit signed/unsigned divider (restoring radix-2, 33-cycle latency)
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        valid,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [4:0] cnt;
  logic [31:0] qr, d, a_mag, b_mag, q_fix, r_fix;
  logic [32:0] r, sh, diff;
  logic qs, rs, go;
  always_comb begin
    go = start && !cancel;
    a_mag = (signed_div && a[31]) ? -a : a;
    b_mag = (signed_div && b[31]) ? -b : b;
    sh = {r[31:0], qr[31]};
    diff = sh - {1'b0, d};
    q_fix = qs ? -qr : qr;
    r_fix = rs ? -r[31:0] : r[31:0];
    busy = state != IDLE;
    valid = state == DONE;
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = go ? RUN : IDLE;
      RUN:  state_nx = cancel ? IDLE : (cnt == 5'd31 ? FIX : RUN);
      FIX:  state_nx = cancel ? IDLE : DONE;
      DONE: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      qr <= '0;
      r <= '0;
      d <= '0;
      qs <= 1'b0;
      rs <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && go) begin
        cnt <= '0;
        qr <= a_mag;
        d <= b_mag;
        r <= '0;
        qs <= signed_div && (a[31] ^ b[31]);
        rs <= signed_div && a[31];
      end
      if (state == RUN) begin
        cnt <= cnt + 5'd1;
        r <= diff[32] ? sh : diff;
        qr <= {qr[30:0], ~diff[32]};
      end
      // a zero divisor leaves |a| in r and all-ones in qr; only the quotient sign must be skipped
      if (state == FIX && !cancel) begin
        quotient <= (d == '0) ? '1 : q_fix;
        remainder <= r_fix;
        div_by_zero <= d == '0;
      end
    end
  end
endmodule
